cic_rate_ctrl: RTL and testbench



---
 rtl/cic_rate_ctrl_pkg.sv | 17 +
 rtl/cic_ctrl_sat_cnt.sv | 26 ++
 rtl/cic_rate_ctrl.sv | 115 +++++++++++
 tb/tb_cic_rate_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cic_rate_ctrl_pkg.sv
// Shared types and helpers for the CIC rate controller.
package cic_rate_ctrl_pkg;

  typedef enum logic [1:0] {
    FLUSH,
    SETTLE,
    RUN
  } state_t;

  // Zero is not a legal decimation rate; anything above the CIC's capacity pins to RMAX.
  function automatic int clamp_rate(input int rate, input int rmax);
    if (rate <= 0) return 1;
    if (rate > rmax) return rmax;
    return rate;
  endfunction

endpackage

// File: rtl/cic_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module cic_ctrl_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cic_rate_ctrl.sv
// Run-time rate controller for the CIC decimator: flushes on every rate change and hides transients.
// Optional stall statistics port enabled by defining CIC_RATE_CTRL_STATS_EN.
module cic_rate_ctrl
  import cic_rate_ctrl_pkg::*;
#(
  parameter int RMAX         = 8,
  parameter int N            = 2,
  parameter int M            = 1,
  parameter int RATE_DEFAULT = 4,
  parameter int RST_CYCLES   = 2,
  parameter int RW           = $clog2(RMAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [RW-1:0] cfg_rate,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  output logic [RW-1:0] cic_rate,
  output logic          cic_rst,
  input  logic          cic_out_tvalid,
  output logic          cic_out_tready,
  output logic          out_tvalid,
  input  logic          out_tready,
  output logic          settled
`ifdef CIC_RATE_CTRL_STATS_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int SETTLE_BEATS = N * M;
  localparam int FW = $clog2(RST_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_BEATS + 1);

  state_t        r_state;
  logic [FW-1:0] r_flush_cnt;
  logic [SW-1:0] r_settle_cnt;
  logic [RW-1:0] r_cic_rate;
  logic          r_cic_rst;

  logic w_run;
  logic w_settle;
  logic w_cfg_acc;

  assign w_run    = (r_state == RUN);
  assign w_settle = (r_state == SETTLE);

  // Pass-through in RUN is purely combinational so the consumer sees no added latency.
  assign cfg_ready      = w_run | w_settle;
  assign w_cfg_acc      = cfg_valid & cfg_ready;
  assign cic_out_tready = w_settle | (w_run & out_tready);
  assign out_tvalid     = w_run & cic_out_tvalid;
  assign settled        = w_run;
  assign cic_rate       = r_cic_rate;
  assign cic_rst        = r_cic_rst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FLUSH;
      r_cic_rate   <= RW'(RATE_DEFAULT);
      r_cic_rst    <= 1'b1;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
    end else if (w_cfg_acc) begin
      // A new request wins over any settle beat in the same cycle; that beat is dropped uncounted.
      r_state      <= FLUSH;
      r_cic_rate   <= RW'(clamp_rate(int'(cfg_rate), RMAX));
      r_cic_rst    <= 1'b1;
      r_flush_cnt  <= '0;
      r_settle_cnt <= '0;
    end else begin
      case (r_state)
        FLUSH: begin
          if (r_flush_cnt == FW'(RST_CYCLES - 1)) begin
            r_state     <= SETTLE;
            r_cic_rst   <= 1'b0;
            r_flush_cnt <= '0;
          end else begin
            r_flush_cnt <= r_flush_cnt + FW'(1);
          end
        end
        SETTLE: begin
          if (cic_out_tvalid) begin
            if (r_settle_cnt == SW'(SETTLE_BEATS - 1)) begin
              r_state      <= RUN;
              r_settle_cnt <= '0;
            end else begin
              r_settle_cnt <= r_settle_cnt + SW'(1);
            end
          end
        end
        RUN: begin
          r_state <= RUN;
        end
        default: begin
          r_state   <= FLUSH;
          r_cic_rst <= 1'b1;
        end
      endcase
    end
  end

`ifdef CIC_RATE_CTRL_STATS_EN
  cic_ctrl_sat_cnt #(
    .W(16)
  ) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_cfg_acc),
    .i_inc (out_tvalid & ~out_tready),
    .o_cnt (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_cic_rate_ctrl.sv
// Directed + randomized bench for cic_rate_ctrl against a phase-counting reference model.
module tb_cic_rate_ctrl;

  localparam int RMAX         = 8;
  localparam int N            = 2;
  localparam int M            = 1;
  localparam int RATE_DEFAULT = 4;
  localparam int RST_CYCLES   = 2;
  localparam int RW           = $clog2(RMAX + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RW-1:0] cfg_rate;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [RW-1:0] cic_rate;
  logic          cic_rst;
  logic          cic_out_tvalid;
  logic          cic_out_tready;
  logic          out_tvalid;
  logic          out_tready;
  logic          settled;
`ifdef CIC_RATE_CTRL_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  cic_rate_ctrl #(
    .RMAX(RMAX), .N(N), .M(M), .RATE_DEFAULT(RATE_DEFAULT), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_rate       (cfg_rate),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .cic_rate       (cic_rate),
    .cic_rst        (cic_rst),
    .cic_out_tvalid (cic_out_tvalid),
    .cic_out_tready (cic_out_tready),
    .out_tvalid     (out_tvalid),
    .out_tready     (out_tready),
    .settled        (settled)
`ifdef CIC_RATE_CTRL_STATS_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: how many flush cycles and discard beats remain before data flows.
  int m_rate;
  int m_flush_left;
  int m_discard_left;
  int m_stall;

  function automatic int ref_clamp(input int r);
    if (r == 0) return 1;
    if (r > RMAX) return RMAX;
    return r;
  endfunction

  task automatic model_reset();
    m_rate         = RATE_DEFAULT;
    m_flush_left   = RST_CYCLES;
    m_discard_left = N * M;
    m_stall        = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, check combinational/registered outputs, clock, advance model.
  task automatic cycle(input bit cv, input int cr, input bit bv, input bit rdy);
    bit in_flush;
    bit in_run;
    cfg_valid      = cv;
    cfg_rate       = RW'(cr);
    cic_out_tvalid = bv;
    out_tready     = rdy;
    #1;
    in_flush = (m_flush_left > 0);
    in_run   = !in_flush && (m_discard_left == 0);
    check("cic_rst", {31'd0, cic_rst}, {31'd0, in_flush});
    check("cic_rate", {{(32-RW){1'b0}}, cic_rate}, m_rate);
    check("cfg_ready", {31'd0, cfg_ready}, {31'd0, !in_flush});
    check("settled", {31'd0, settled}, {31'd0, in_run});
    check("out_tvalid", {31'd0, out_tvalid}, {31'd0, in_run && bv});
    check("cic_out_tready", {31'd0, cic_out_tready},
          {31'd0, in_flush ? 1'b0 : (in_run ? rdy : 1'b1)});
`ifdef CIC_RATE_CTRL_STATS_EN
    check("stall_cnt", {16'd0, stall_cnt}, m_stall);
`endif
    @(posedge clk);
    if (!in_flush && cv) begin
      m_rate         = ref_clamp(cr);
      m_flush_left   = RST_CYCLES;
      m_discard_left = N * M;
      m_stall        = 0;
    end else if (in_flush) begin
      m_flush_left--;
    end else if (!in_run && bv) begin
      m_discard_left--;
    end else if (in_run && bv && !rdy && m_stall < 65535) begin
      m_stall++;
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n          = 1'b0;
    cfg_valid      = 1'b0;
    cfg_rate       = '0;
    cic_out_tvalid = 1'b1;
    out_tready     = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_cic_rst", {31'd0, cic_rst}, 32'd1);
    check("rst_cic_rate", {{(32-RW){1'b0}}, cic_rate}, RATE_DEFAULT);
    check("rst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    rst_n = 1'b1;

    // Release: two flush cycles, two discards, third beat passes.
    repeat (2) cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 1, 1);
    check("run_after_release", {31'd0, settled}, 32'd1);

    // Rate 6 in RUN alongside a beat handshake.
    cycle(1, 6, 1, 1);
    check("rate6_next", {{(32-RW){1'b0}}, cic_rate}, 32'd6);
    check("rate6_rst", {31'd0, cic_rst}, 32'd1);
    repeat (2) cycle(0, 0, 0, 1);
    repeat (3) cycle(0, 0, 1, 1);

    // Clamp both ends.
    cycle(1, 0, 1, 1);
    check("clamp0", {{(32-RW){1'b0}}, cic_rate}, 32'd1);
    repeat (4) cycle(0, 0, 1, 1);
    cycle(1, 15, 0, 1);
    check("clamp15", {{(32-RW){1'b0}}, cic_rate}, 32'd8);
    repeat (2) cycle(0, 0, 0, 1);

    // Request mid-SETTLE after one discard: same-cycle beat is dropped.
    cycle(0, 0, 1, 1);
    cycle(1, 3, 1, 1);
    repeat (2) cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);
    check("midsettle_still_settling", {31'd0, settled}, 32'd0);
    cycle(0, 0, 1, 1);
    cycle(0, 0, 1, 1);

    // Backpressure in RUN.
    repeat (5) cycle(0, 0, 1, 0);
`ifdef CIC_RATE_CTRL_STATS_EN
    check("stall5", {16'd0, stall_cnt}, 32'd5);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) == 0), int'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 20; i++) begin
      if (m_flush_left > 0 || m_discard_left > 0) cycle(0, 0, 1, 1);
    end

    // Async reset mid-RUN, checked before any clock edge.
    cic_out_tvalid = 1'b1;
    out_tready     = 1'b1;
    cfg_valid      = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cic_rst", {31'd0, cic_rst}, 32'd1);
    check("arst_cic_rate", {{(32-RW){1'b0}}, cic_rate}, RATE_DEFAULT);
    check("arst_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    check("arst_out_tvalid", {31'd0, out_tvalid}, 32'd0);
    check("arst_cic_out_tready", {31'd0, cic_out_tready}, 32'd0);
    check("arst_settled", {31'd0, settled}, 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) cycle(0, 0, 1, 1);
    repeat (3) cycle(0, 0, 1, 1);
    check("run_after_rerelease", {31'd0, settled}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
